// File: rtl/sort_pkg.sv
// Shared types and default sizing for the packet sorter sequencer.
package sort_pkg;

  localparam int unsigned DWIDTH_DEF = 8;
  localparam int unsigned AWIDTH_DEF = 4;
  localparam int unsigned DEPTH_DEF  = 2**AWIDTH_DEF;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    GAP,
    LOAD,
    SORT
  } sort_state_t;

endpackage

// File: rtl/sort_buf_ram.sv
// Packet buffer: one write port, one registered read port, old data on collision.
module sort_buf_ram #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic [AWIDTH-1:0] rd_addr_i,
  output logic [DWIDTH-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 2**AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sort_ctrl.sv
// Sequencer: captures one upstream packet into the buffer, replays it into the
// sorter's load interface, then holds upstream off until the sorter finishes.
module sort_ctrl
  import sort_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned AWIDTH = AWIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              val_i,
  output logic              busy_o,
  output logic              srt_wren_o,
  output logic [AWIDTH-1:0] srt_cntr_o,
  output logic [DWIDTH-1:0] srt_data_o,
  input  logic [AWIDTH-1:0] srt_rdaddr_i,
  input  logic              srt_eop_i,
  output logic              err_o
);

  localparam logic [AWIDTH:0] FULL = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] ONE  = {{AWIDTH{1'b0}}, 1'b1};

  sort_state_t       state_q, state_d;
  logic [AWIDTH:0]   wcnt_q, wcnt_d, wcnt_nxt;
  logic [AWIDTH:0]   lcnt_q, lcnt_d;
  logic [AWIDTH-1:0] cntr_q, cntr_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic              ram_we;
  logic [AWIDTH-1:0] ram_waddr;

  sort_buf_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_buf (
    .clk_i     (clk_i),
    .wr_en_i   (ram_we),
    .wr_addr_i (ram_waddr),
    .wr_data_i (data_i),
    .rd_addr_i (srt_rdaddr_i),
    .rd_data_o (srt_data_o)
  );

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    lcnt_d    = lcnt_q;
    cntr_d    = cntr_q;
    ovf_d     = ovf_q;
    wren_d    = 1'b0;
    err_d     = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = wcnt_q[AWIDTH-1:0];
    wcnt_nxt  = (wcnt_q == FULL) ? wcnt_q : wcnt_q + ONE;

    unique case (state_q)
      IDLE: begin
        if (val_i && sop_i) begin
          if (eop_i) begin
            err_d = 1'b1;
          end else begin
            ram_we    = 1'b1;
            ram_waddr = '0;
            wcnt_d    = ONE;
            ovf_d     = 1'b0;
            state_d   = WRITE;
          end
        end
      end
      WRITE: begin
        if (val_i) begin
          if (sop_i) begin
            // Restart on a fresh sop; a restart that is also eop is a dropped 1-word packet.
            err_d = 1'b1;
            if (eop_i) begin
              wcnt_d  = '0;
              state_d = IDLE;
            end else begin
              ram_we    = 1'b1;
              ram_waddr = '0;
              wcnt_d    = ONE;
              ovf_d     = 1'b0;
            end
          end else begin
            if (wcnt_q == FULL) begin
              err_d = !ovf_q;
              ovf_d = 1'b1;
            end else begin
              ram_we = 1'b1;
              wcnt_d = wcnt_nxt;
            end
            if (eop_i) begin
              cntr_d  = wcnt_nxt[AWIDTH-1:0];
              state_d = GAP;
            end
          end
        end
      end
      GAP: begin
        wren_d  = 1'b1;
        lcnt_d  = wcnt_q - ONE;
        state_d = LOAD;
      end
      LOAD: begin
        if (lcnt_q == '0) begin
          state_d = SORT;
        end else begin
          wren_d = 1'b1;
          lcnt_d = lcnt_q - ONE;
        end
      end
      SORT: begin
        if (srt_eop_i) begin
          wcnt_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (val_i && ((state_q == GAP) || (state_q == LOAD) || (state_q == SORT))) begin
      err_d = 1'b1;
    end

    busy_d = (state_d == GAP) || (state_d == LOAD) || (state_d == SORT);
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      lcnt_q  <= '0;
      cntr_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      lcnt_q  <= lcnt_d;
      cntr_q  <= cntr_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o     = busy_q;
  assign srt_wren_o = wren_q;
  assign srt_cntr_o = cntr_q;
  assign err_o      = err_q;

endmodule
